div_unit: RTL and testbench

- Iterative 32-cycle restoring divider for the core's M-extension ops: DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage.
- Takes operands through a valid/ready request port and returns one 32-bit result through a valid/ready response port.
- Execute stalls on in_ready_o / out_valid_o.

---
 rtl/div_unit.sv | 144 ++++++++++++++
 tb/tb_div_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; special cases resolve at accept.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             rsel_q, rsel_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             rdy_q, rdy_d;

  logic             sgn, a_neg, b_neg, ovf, ge;
  logic [WIDTH-1:0] amag, bmag;
  logic [WIDTH:0]   rem_sh, sub;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix;

  always_comb begin
    sgn    = ~op_i[0];
    a_neg  = sgn & a_i[WIDTH-1];
    b_neg  = sgn & b_i[WIDTH-1];
    amag   = a_neg ? -a_i : a_i;
    bmag   = b_neg ? -b_i : b_i;
    ovf    = sgn && (a_i == {1'b1, {(WIDTH-1){1'b0}}})
                 && (b_i == {WIDTH{1'b1}});
    // rem_q < bmag_q always holds, so the borrow bit is the compare
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    sub    = rem_sh - {1'b0, bmag_q};
    ge     = ~sub[WIDTH];
    rem_nx = ge ? sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    // quotient bits enter the dividend register from the bottom
    quo_nx = {dvd_q[WIDTH-2:0], ge};
    q_fix  = negq_q ? -quo_nx : quo_nx;
    r_fix  = negr_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    bmag_d  = bmag_q;
    out_d   = out_q;
    rsel_d  = rsel_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i && rdy_q && !kill_i) begin
          rsel_d = op_i[1];
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          bmag_d = bmag;
          dvd_d  = amag;
          rem_d  = '0;
          cnt_d  = '0;
          if (b_i == '0) begin
            state_d = DONE;
            out_d   = op_i[1] ? a_i : {WIDTH{1'b1}};
          end else if (ovf) begin
            state_d = DONE;
            out_d   = op_i[1] ? '0 : a_i;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          dvd_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = DONE;
            out_d   = rsel_q ? r_fix : q_fix;
          end
        end
      end
      DONE: begin
        if (kill_i || out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      bmag_q  <= '0;
      out_q   <= '0;
      rsel_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      bmag_q  <= bmag_d;
      out_q   <= out_d;
      rsel_q  <= rsel_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = (state_q == DONE);
  assign out_o       = out_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, flow control,
// abort, reset and a reference-model sweep.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .kill_i      (kill),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_o       (out)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: result is consumed at the next edge when valid && ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !kill) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", out, 32'hxxxx_xxxx);
      end else begin
        chk("result", out, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] ref_div(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    logic ov;
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    case (o)
      2'b00:   return ov ? x : 32'($signed(x) / $signed(y));
      2'b01:   return x / y;
      2'b10:   return ov ? 32'h0 : 32'($signed(x) % $signed(y));
      default: return x % y;
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) exp_q.push_back(ref_div(o, x, y));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
  } vec_t;

  vec_t vecs[10] = '{
    '{2'b01, 32'd20,         32'd3,          33},
    '{2'b11, 32'd20,         32'd3,          33},
    '{2'b00, 32'hFFFF_FFEC,  32'd3,          33},
    '{2'b10, 32'hFFFF_FFEC,  32'd3,          33},
    '{2'b00, 32'd20,         32'hFFFF_FFFD,  33},
    '{2'b10, 32'd20,         32'hFFFF_FFFD,  33},
    '{2'b01, 32'd7,          32'd0,          1},
    '{2'b11, 32'd7,          32'd0,          1},
    '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  1},
    '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  1}
  };

  logic [31:0] hand[10] = '{
    32'd6, 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFA,
    32'd2, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0
  };

  logic [31:0] corner[6] = '{
    32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2
  };

  initial begin
    int lat;
    bit stable;
    logic [31:0] held, x, y;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    kill = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    rst_n = 1'b1;

    // hand-computed vectors: scoreboard value, latency, ready
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(hand[i]);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      if (vecs[i].lat > 1)
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      wait_valid(lat);
      chk("latency", lat, vecs[i].lat);
      chk("done_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("after_in_ready", {31'd0, in_ready}, 32'd1);
    end

    // backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(2'b01, 32'd20, 32'd3, 1'b1);
    wait_valid(lat);
    held = out;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out !== held || in_ready) stable = 1'b0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_value", held, 32'd6);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd1);

    // abort in BUSY
    issue(2'b01, 32'd50, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_valid", {31'd0, out_valid}, 32'd0);
    chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
    stable = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stable = 1'b0;
    end
    chk("kill_no_result", {31'd0, stable}, 32'd1);
    issue(2'b01, 32'd100, 32'd7, 1'b1);
    wait_valid(lat);
    chk("post_kill_lat", lat, 33);
    @(negedge clk);

    // reset in BUSY
    issue(2'b00, 32'd1000, 32'd9, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstb_valid", {31'd0, out_valid}, 32'd0);
    chk("rstb_out", out, 32'd0);
    chk("rstb_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // reset in DONE
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(2'b11, 32'd55, 32'd0, 1'b0);
    wait_valid(lat);
    chk("rstd_pre", out, 32'd55);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstd_valid", {31'd0, out_valid}, 32'd0);
    chk("rstd_out", out, 32'd0);
    chk("rstd_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // reference-model sweep with corner operands
    for (int i = 0; i < 300; i++) begin
      x = $urandom();
      y = $urandom();
      if ($urandom_range(0, 2) == 0) x = corner[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0) y = corner[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
      issue(2'($urandom_range(0, 3)), x, y, 1'b1);
      wait_valid(lat);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
